mem_port_arbiter: RTL and testbench

- Shares the single memory port between two requesters: instruction fetch (IF stage) and load/store (MEM stage).
- Sequences every memory transaction through a small FSM and drives the stall signal the pipeline uses when its port is busy.
- Sits between the pipeline stages and the memory model. Data requests have priority, and a starvation guard bounds how long fetch can be locked out.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 547 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM/owner encodings, width constants
// and small helpers used by the arbiter datapath.
package mem_port_arbiter_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Instructions are 32-bit; address bit 2 picks the half of the 64-bit beat.
  function automatic logic [INST_W-1:0] sel_word(input logic [XLEN-1:0] beat,
                                                 input logic            hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

  function automatic logic [63:0] sat_inc64(input logic [63:0] value);
    return (value == 64'hFFFF_FFFF_FFFF_FFFF) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single memory port with a
// starvation guard. Optional MEM_ARB_PERF_EN adds saturating perf counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [INST_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [7:0]        d_wmask_i,
  output logic              d_ready_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic [7:0]        m_wmask_o,
  input  logic              m_ack_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [63:0]       perf_if_o,
  output logic [63:0]       perf_d_o,
  output logic [63:0]       perf_busy_o,
  output logic [63:0]       perf_starve_o
`endif
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state;
  logic             owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             at_limit;
  logic             grant_d;
  logic             grant_if;
  logic             force_if;

  assign at_limit = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT_C);

  // Data wins ties unless fetch has already lost STARVE_LIMIT grants in a row.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    force_if = 1'b0;
    if (state == ST_IDLE) begin
      if (d_req_i && if_req_i) begin
        if (at_limit) begin
          grant_if = 1'b1;
          force_if = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else if (d_req_i) begin
        grant_d = 1'b1;
      end else if (if_req_i) begin
        grant_if = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      m_req_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_addr_o   <= '0;
      m_wdata_o  <= '0;
      m_wmask_o  <= '0;
      if_ready_o <= 1'b0;
      d_ready_o  <= 1'b0;
      if_rdata_o <= '0;
      d_rdata_o  <= '0;
    end else begin
      if_ready_o <= 1'b0;
      d_ready_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state     <= ST_BUSY;
            owner     <= OWN_D;
            m_req_o   <= 1'b1;
            m_we_o    <= d_we_i;
            m_addr_o  <= d_addr_i;
            m_wdata_o <= d_wdata_i;
            m_wmask_o <= d_wmask_i;
          end else if (grant_if) begin
            state     <= ST_BUSY;
            owner     <= OWN_IF;
            m_req_o   <= 1'b1;
            m_we_o    <= 1'b0;
            m_addr_o  <= if_addr_i;
            m_wdata_o <= '0;
            m_wmask_o <= '0;
          end
        end
        ST_BUSY: begin
          // The m_* registers are left untouched here so memory sees a stable request.
          if (m_ack_i) begin
            state   <= ST_RESP;
            m_req_o <= 1'b0;
            if (owner == OWN_D) begin
              d_rdata_o <= m_rdata_i;
              d_ready_o <= 1'b1;
            end else begin
              if_rdata_o <= sel_word(m_rdata_i, m_addr_o[2]);
              if_ready_o <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Counts data grants taken while fetch was waiting; saturates at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && if_req_i && (starve_cnt != LIMIT_C)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign stall_if_o  = if_req_i & ~if_ready_o;
  assign stall_mem_o = d_req_i & ~d_ready_o;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_if_o     <= '0;
      perf_d_o      <= '0;
      perf_busy_o   <= '0;
      perf_starve_o <= '0;
    end else begin
      if (grant_if)          perf_if_o     <= sat_inc64(perf_if_o);
      if (grant_d)           perf_d_o      <= sat_inc64(perf_d_o);
      if (state == ST_BUSY)  perf_busy_o   <= sat_inc64(perf_busy_o);
      if (force_if)          perf_starve_o <= sat_inc64(perf_starve_o);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model and a memory model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int LIMIT  = 4;

  logic              clock;
  logic              reset;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ready_o;
  logic [31:0]       if_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [7:0]        d_wmask_i;
  logic              d_ready_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              m_req_o;
  logic              m_we_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_wdata_o;
  logic [7:0]        m_wmask_o;
  logic              m_ack_i;
  logic [DATA_W-1:0] m_rdata_i;
  logic              stall_if_o;
  logic              stall_mem_o;
`ifdef MEM_ARB_PERF_EN
  logic [63:0]       perf_if_o;
  logic [63:0]       perf_d_o;
  logic [63:0]       perf_busy_o;
  logic [63:0]       perf_starve_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_wmask_i(d_wmask_i), .d_ready_o(d_ready_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_wmask_o(m_wmask_o), .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_o(perf_if_o), .perf_d_o(perf_d_o),
    .perf_busy_o(perf_busy_o), .perf_starve_o(perf_starve_o)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: sparse 64-bit words keyed by dword address, with a
  // deterministic address-derived pattern for untouched locations.
  logic [63:0] mem [logic [60:0]];
  bit          mem_auto;
  int          ack_delay;
  int          cur_delay;
  int          mem_wait;
  bit          mem_active;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a[63:3])) return mem[a[63:3]];
    return {a[31:0] ^ 32'h5A5A_1234, ~a[34:3]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Responder: acks the held request after cur_delay extra BUSY cycles.
  task automatic mem_step();
    logic [63:0] data;
    if (!mem_auto) return;
    if (m_ack_i) begin
      m_ack_i    = 1'b0;
      mem_active = 1'b0;
      mem_wait   = 0;
      return;
    end
    if (m_req_o) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_wait   = 0;
        cur_delay  = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
      end
      if (mem_wait >= cur_delay) begin
        data      = mem_rd(m_addr_o);
        m_rdata_i = data;
        if (m_we_o) begin
          for (int b = 0; b < 8; b++)
            if (m_wmask_o[b]) data[8*b +: 8] = m_wdata_o[8*b +: 8];
          mem[m_addr_o[63:3]] = data;
        end
        m_ack_i = 1'b1;
      end else begin
        mem_wait++;
      end
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    d_req_i    = 1'b0;
    d_we_i     = 1'b0;
    d_addr_i   = '0;
    d_wdata_i  = '0;
    d_wmask_i  = '0;
    m_ack_i    = 1'b0;
    m_rdata_i  = '0;
    mem_auto   = 1'b1;
    ack_delay  = 0;
    mem_wait   = 0;
    mem_active = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({m_req_o, m_we_o, m_wmask_o, if_ready_o, d_ready_o, stall_if_o, stall_mem_o} !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b want 0", {m_req_o, m_we_o, m_wmask_o, if_ready_o, d_ready_o, stall_if_o, stall_mem_o});
    end
    n_cmp++;
    if ({m_addr_o, m_wdata_o} !== 128'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mbus: got addr %h wdata %h want 0", m_addr_o, m_wdata_o);
    end
    n_cmp++;
    if ({if_rdata_o, d_rdata_o} !== 96'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_rdata: got if %h d %h want 0", if_rdata_o, d_rdata_o);
    end
  endtask

  task automatic test_single_fetch();
    logic [63:0] a;
    do_reset();
    a = 64'h8000_0004;
    mem[a[63:3]] = 64'h0050_0093_0010_0073;
    if_addr_i = a;
    if_req_i  = 1'b1;
    tick();
    n_cmp++;
    if ({m_req_o, m_we_o, m_addr_o} !== {1'b1, 1'b0, 64'h8000_0004}) begin
      n_fail++;
      $display("[TB] FAIL fetch_issue: got req %b we %b addr %h want 1 0 80000004", m_req_o, m_we_o, m_addr_o);
    end
    n_cmp++;
    if ({if_ready_o, stall_if_o} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL fetch_wait: got ready %b stall %b want 0 1", if_ready_o, stall_if_o);
    end
    mem_step();
    tick();
    n_cmp++;
    if ({if_ready_o, d_ready_o, stall_if_o} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL fetch_ready: got if_ready %b d_ready %b stall %b want 1 0 0", if_ready_o, d_ready_o, stall_if_o);
    end
    n_cmp++;
    if (if_rdata_o !== 32'h0050_0093) begin
      n_fail++;
      $display("[TB] FAIL fetch_data: got %h want 00500093", if_rdata_o);
    end
    if_req_i = 1'b0;
    mem_step();
    tick();
    n_cmp++;
    if ({if_ready_o, m_req_o} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL fetch_pulse: got ready %b req %b want 0 0", if_ready_o, m_req_o);
    end
  endtask

  task automatic test_priority();
    logic [63:0] exp_d;
    logic [63:0] exp_i;
    do_reset();
    if_addr_i = 64'h8000_0010;
    d_addr_i  = 64'h8000_0100;
    d_we_i    = 1'b0;
    exp_d     = mem_rd(64'h8000_0100);
    exp_i     = mem_rd(64'h8000_0010);
    if_req_i  = 1'b1;
    d_req_i   = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      n_cmp++;
      if (stall_if_o !== (t != 5)) begin
        n_fail++;
        $display("[TB] FAIL prio_stall_if t=%0d: got %b want %b", t, stall_if_o, t != 5);
      end
      case (t)
        1: begin
          n_cmp++;
          if ({m_req_o, m_we_o, m_addr_o} !== {1'b1, 1'b0, 64'h8000_0100}) begin
            n_fail++;
            $display("[TB] FAIL prio_data_first: got req %b we %b addr %h want 1 0 80000100", m_req_o, m_we_o, m_addr_o);
          end
        end
        2: begin
          n_cmp++;
          if ({d_ready_o, d_rdata_o} !== {1'b1, exp_d}) begin
            n_fail++;
            $display("[TB] FAIL prio_load: got ready %b data %h want 1 %h", d_ready_o, d_rdata_o, exp_d);
          end
          d_req_i = 1'b0;
        end
        3: begin
          n_cmp++;
          if (m_req_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL prio_turnaround: got req %b want 0", m_req_o);
          end
        end
        4: begin
          n_cmp++;
          if ({m_req_o, m_addr_o} !== {1'b1, 64'h8000_0010}) begin
            n_fail++;
            $display("[TB] FAIL prio_fetch_issue: got req %b addr %h want 1 80000010", m_req_o, m_addr_o);
          end
        end
        default: begin
          n_cmp++;
          if ({if_ready_o, if_rdata_o} !== {1'b1, exp_i[31:0]}) begin
            n_fail++;
            $display("[TB] FAIL prio_fetch_done: got ready %b data %h want 1 %h", if_ready_o, if_rdata_o, exp_i[31:0]);
          end
          if_req_i = 1'b0;
        end
      endcase
      mem_step();
    end
  endtask

  task automatic test_starvation();
    int   g;
    logic is_fetch;
    do_reset();
    g         = 0;
    if_addr_i = 64'h1000_0040;
    d_addr_i  = 64'h2000_0080;
    d_we_i    = 1'b0;
    if_req_i  = 1'b1;
    d_req_i   = 1'b1;
    for (int t = 0; t < 200 && g < 10; t++) begin
      tick();
      if (m_req_o && !mem_active) begin
        is_fetch = (m_addr_o == if_addr_i);
        n_cmp++;
        if (is_fetch !== ((g % 5) == 4)) begin
          n_fail++;
          $display("[TB] FAIL starve_grant%0d: got fetch=%b want %b", g, is_fetch, (g % 5) == 4);
        end
        g++;
      end
      mem_step();
    end
    n_cmp++;
    if (g != 10) begin
      n_fail++;
      $display("[TB] FAIL starve_budget: got %0d grants want 10", g);
    end
  endtask

  task automatic test_store_wait();
    logic [63:0] old_val;
    logic [63:0] now_val;
    int          extra;
    do_reset();
    ack_delay = 4;
    old_val   = mem_rd(64'h8000_0200);
    d_addr_i  = 64'h8000_0200;
    d_we_i    = 1'b1;
    d_wdata_i = 64'h1122_3344_5566_7788;
    d_wmask_i = 8'h0F;
    d_req_i   = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      n_cmp++;
      if ({m_req_o, m_we_o, m_wmask_o, m_addr_o, m_wdata_o, d_ready_o} !==
          {1'b1, 1'b1, 8'h0F, 64'h8000_0200, 64'h1122_3344_5566_7788, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL store_hold t=%0d: got req %b we %b mask %h addr %h wdata %h ready %b", t,
                 m_req_o, m_we_o, m_wmask_o, m_addr_o, m_wdata_o, d_ready_o);
      end
      mem_step();
    end
    tick();
    n_cmp++;
    if (d_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL store_ready: got %b want 1", d_ready_o);
    end
    d_req_i = 1'b0;
    mem_step();
    extra = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      extra += int'(m_req_o) + int'(d_ready_o);
      mem_step();
    end
    n_cmp++;
    if (extra != 0) begin
      n_fail++;
      $display("[TB] FAIL store_dup: got %0d extra req/ready cycles want 0", extra);
    end
    now_val = mem_rd(64'h8000_0200);
    n_cmp++;
    if (now_val !== {old_val[63:32], 32'h5566_7788}) begin
      n_fail++;
      $display("[TB] FAIL store_mask: got %h want %h", now_val, {old_val[63:32], 32'h5566_7788});
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    mem_auto = 1'b0;
    d_addr_i = 64'h8000_0300;
    d_we_i   = 1'b0;
    d_req_i  = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (m_req_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_busy_pre: got req %b want 1", m_req_o);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({m_req_o, m_we_o, m_wmask_o, m_addr_o} !== 74'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_busy_abort: got req %b addr %h want 0", m_req_o, m_addr_o);
    end
    reset     = 1'b0;
    d_req_i   = 1'b0;
    m_ack_i   = 1'b1;
    m_rdata_i = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    m_ack_i = 1'b0;
    for (int t = 0; t < 3; t++) begin
      n_cmp++;
      if ({if_ready_o, d_ready_o, m_req_o, d_rdata_o, if_rdata_o} !== 99'd0) begin
        n_fail++;
        $display("[TB] FAIL rst_stray_ack t=%0d: got ready %b/%b req %b d %h if %h want 0", t,
                 if_ready_o, d_ready_o, m_req_o, d_rdata_o, if_rdata_o);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int          consec;
    int          age;
    int          cyc;
    int          n_if_done;
    int          n_d_done;
    bit          txn_open;
    bit          exp_data;
    logic [31:0] exp_if;
    logic [63:0] exp_d;
    logic [31:0] last_if;
    logic [63:0] last_d;
    logic [63:0] beat;
    do_reset();
    ack_delay = -1;
    consec    = 0;
    age       = 0;
    cyc       = 0;
    n_if_done = 0;
    n_d_done  = 0;
    txn_open  = 1'b0;
    exp_data  = 1'b0;
    exp_if    = '0;
    exp_d     = '0;
    last_if   = '0;
    last_d    = '0;
    while (cyc < 600 && (cyc < 400 || if_req_i || d_req_i || txn_open)) begin
      tick();
      cyc++;
      n_cmp++;
      if ({stall_if_o, stall_mem_o} !== {if_req_i && !if_ready_o, d_req_i && !d_ready_o}) begin
        n_fail++;
        $display("[TB] FAIL rnd_stall c=%0d: got %b%b", cyc, stall_if_o, stall_mem_o);
      end
      if (m_req_o && !mem_active) begin
        n_cmp++;
        if (txn_open) begin
          n_fail++;
          $display("[TB] FAIL rnd_overlap c=%0d: new grant while a transaction is open", cyc);
        end
        exp_data = d_req_i && !(if_req_i && LIMIT != 0 && consec == LIMIT);
        n_cmp++;
        if (exp_data) begin
          if ({m_we_o, m_wmask_o, m_addr_o, m_wdata_o} !== {d_we_i, d_wmask_i, d_addr_i, d_wdata_i}) begin
            n_fail++;
            $display("[TB] FAIL rnd_grant_d c=%0d: got we %b mask %h addr %h want %b %h %h", cyc,
                     m_we_o, m_wmask_o, m_addr_o, d_we_i, d_wmask_i, d_addr_i);
          end
          consec = if_req_i ? ((consec < LIMIT) ? consec + 1 : LIMIT) : consec;
          exp_d  = mem_rd(d_addr_i);
        end else begin
          if ({m_we_o, m_wmask_o, m_addr_o} !== {1'b0, 8'h00, if_addr_i}) begin
            n_fail++;
            $display("[TB] FAIL rnd_grant_if c=%0d: got we %b mask %h addr %h want 0 00 %h", cyc,
                     m_we_o, m_wmask_o, m_addr_o, if_addr_i);
          end
          consec = 0;
          beat   = mem_rd(if_addr_i);
          exp_if = if_addr_i[2] ? beat[63:32] : beat[31:0];
        end
        txn_open = 1'b1;
        age      = 0;
      end
      if (if_ready_o || d_ready_o) begin
        n_cmp++;
        if (!txn_open || (if_ready_o && d_ready_o) || (d_ready_o !== exp_data)) begin
          n_fail++;
          $display("[TB] FAIL rnd_ready_owner c=%0d: got if %b d %b want d=%b open=%b", cyc,
                   if_ready_o, d_ready_o, exp_data, txn_open);
        end
        if (d_ready_o) begin
          last_d = exp_d;
          d_req_i = 1'b0;
          n_d_done++;
        end
        if (if_ready_o) begin
          last_if = exp_if;
          if_req_i = 1'b0;
          n_if_done++;
        end
        txn_open = 1'b0;
      end else if (txn_open) begin
        age++;
        n_cmp++;
        if (age > 10) begin
          n_fail++;
          $display("[TB] FAIL rnd_timeout c=%0d: no ready after %0d cycles", cyc, age);
          txn_open = 1'b0;
        end
      end
      n_cmp++;
      if ({if_rdata_o, d_rdata_o} !== {last_if, last_d}) begin
        n_fail++;
        $display("[TB] FAIL rnd_rdata c=%0d: got if %h d %h want if %h d %h", cyc, if_rdata_o, d_rdata_o, last_if, last_d);
      end
      mem_step();
      if (cyc < 400) begin
        if (!if_req_i && $urandom_range(0, 2) == 0) begin
          if_addr_i = 64'h1000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
          if_req_i  = 1'b1;
        end
        if (!d_req_i && $urandom_range(0, 3) != 0) begin
          d_addr_i  = 64'h2000_0000 + 64'($urandom_range(0, 63)) * 64'd8;
          d_we_i    = 1'($urandom_range(0, 1));
          d_wdata_i = {$urandom, $urandom};
          d_wmask_i = 8'($urandom_range(0, 255));
          d_req_i   = 1'b1;
        end
      end
    end
    n_cmp++;
    if (if_req_i || d_req_i || txn_open || n_if_done == 0 || n_d_done == 0) begin
      n_fail++;
      $display("[TB] FAIL rnd_drain: got pending if %b d %b open %b done if %0d d %0d", if_req_i, d_req_i,
               txn_open, n_if_done, n_d_done);
    end
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    int seen;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        if_addr_i = 64'h1000_0000 + 64'(k) * 64'd4;
        if_req_i  = 1'b1;
      end else begin
        d_addr_i = 64'h2000_0000 + 64'(k) * 64'd8;
        d_we_i   = 1'b0;
        d_req_i  = 1'b1;
      end
      seen = 0;
      for (int t = 0; t < 20 && seen == 0; t++) begin
        tick();
        if (if_ready_o || d_ready_o) begin
          seen     = 1;
          if_req_i = 1'b0;
          d_req_i  = 1'b0;
        end
        mem_step();
      end
      n_cmp++;
      if (seen == 0) begin
        n_fail++;
        $display("[TB] FAIL perf_txn%0d: got no ready want ready", k);
      end
      tick();
      mem_step();
    end
    n_cmp++;
    if ({perf_if_o, perf_d_o, perf_starve_o, perf_busy_o} !== {64'd3, 64'd2, 64'd0, 64'd5}) begin
      n_fail++;
      $display("[TB] FAIL perf_counts: got if %0d d %0d starve %0d busy %0d want 3 2 0 5",
               perf_if_o, perf_d_o, perf_starve_o, perf_busy_o);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got simulation still running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_store_wait();
    test_reset_mid_busy();
    test_random();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
